// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared Q16.16 types, widths and atanh table for the hyperbolic CORDIC
package cordic_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;

    typedef logic signed [DATA_W-1:0] q16_t;

    // atanh(2^-iter) in Q16.16; iterations 4 and 13 are not repeated by the chain
    function automatic q16_t atanh_lut(input int iter);
        case (iter)
            1:       atanh_lut = 32'sh0000_8C9F;
            2:       atanh_lut = 32'sh0000_4163;
            3:       atanh_lut = 32'sh0000_202B;
            4:       atanh_lut = 32'sh0000_1005;
            5:       atanh_lut = 32'sh0000_0801;
            6:       atanh_lut = 32'sh0000_0400;
            7:       atanh_lut = 32'sh0000_0200;
            8:       atanh_lut = 32'sh0000_0100;
            9:       atanh_lut = 32'sh0000_0080;
            10:      atanh_lut = 32'sh0000_0040;
            11:      atanh_lut = 32'sh0000_0020;
            12:      atanh_lut = 32'sh0000_0010;
            13:      atanh_lut = 32'sh0000_0008;
            14:      atanh_lut = 32'sh0000_0004;
            15:      atanh_lut = 32'sh0000_0002;
            16:      atanh_lut = 32'sh0000_0001;
            default: atanh_lut = '0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_unit.sv
// rtl/cordic_unit.sv - one registered hyperbolic CORDIC micro-rotation (rotation mode)
module cordic_unit
    import cordic_pkg::*;
#(
    parameter int ITER = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic signed [DATA_W-1:0] ix,
    input  logic signed [DATA_W-1:0] iy,
    input  logic signed [DATA_W-1:0] iz,
    input  logic signed [DATA_W-1:0] atanhLUT,
    output logic signed [DATA_W-1:0] ox,
    output logic signed [DATA_W-1:0] oy,
    output logic signed [DATA_W-1:0] oz
);

    q16_t xs;
    q16_t ys;
    q16_t nx;
    q16_t ny;
    q16_t nz;
    logic d_neg;

    // A zero residual counts as positive, so only the sign bit picks the direction
    always_comb begin
        d_neg = iz[DATA_W-1];
        xs    = ix >>> ITER;
        ys    = iy >>> ITER;
        nx    = ix + ys;
        ny    = iy + xs;
        nz    = iz - atanhLUT;
        if (d_neg) begin
            nx = ix - ys;
            ny = iy - xs;
            nz = iz + atanhLUT;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ox <= '0;
            oy <= '0;
            oz <= '0;
        end else begin
            ox <= nx;
            oy <= ny;
            oz <= nz;
        end
    end

endmodule

// File: tb/tb_cordic_unit.sv
// tb/tb_cordic_unit.sv - self-checking bench for cordic_unit against a real-arithmetic reference
module tb_cordic_unit;

    logic        CLK;
    logic        RST_N;
    logic [31:0] a_ix, a_iy, a_iz, a_lut;
    logic [31:0] b_ix, b_iy, b_iz, b_lut;
    logic [31:0] a_ox, a_oy, a_oz;
    logic [31:0] b_ox, b_oy, b_oz;
    logic [31:0] chx, chy, chz;
    wire  [31:0] sx [0:16];
    wire  [31:0] sy [0:16];
    wire  [31:0] sz [0:16];

    int errors = 0;
    int checks = 0;

    logic [31:0] tbl [1:16] = '{32'h8C9F, 32'h4163, 32'h202B, 32'h1005, 32'h0801, 32'h0400,
                                32'h0200, 32'h0100, 32'h0080, 32'h0040, 32'h0020, 32'h0010,
                                32'h0008, 32'h0004, 32'h0002, 32'h0001};

    cordic_unit #(.ITER(1)) u_a (
        .CLK(CLK), .RST_N(RST_N), .ix(a_ix), .iy(a_iy), .iz(a_iz), .atanhLUT(a_lut),
        .ox(a_ox), .oy(a_oy), .oz(a_oz)
    );

    cordic_unit #(.ITER(2)) u_b (
        .CLK(CLK), .RST_N(RST_N), .ix(b_ix), .iy(b_iy), .iz(b_iz), .atanhLUT(b_lut),
        .ox(b_ox), .oy(b_oy), .oz(b_oz)
    );

    assign sx[0] = chx;
    assign sy[0] = chy;
    assign sz[0] = chz;

    for (genvar g = 0; g < 16; g++) begin : g_chain
        cordic_unit #(.ITER(g + 1)) u_s (
            .CLK(CLK), .RST_N(RST_N), .ix(sx[g]), .iy(sy[g]), .iz(sz[g]),
            .atanhLUT(cordic_pkg::atanh_lut(g + 1)),
            .ox(sx[g+1]), .oy(sy[g+1]), .oz(sz[g+1])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shift modelled as floor division by 2^k, sums done wide then wrapped to 32 bits
    function automatic longint floor_div(input longint v, input int k);
        return longint'($floor(real'(v) / (2.0 ** k)));
    endfunction

    task automatic model(input int k, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [31:0] a,
                         output logic [31:0] ex, output logic [31:0] ey, output logic [31:0] ez);
        longint lx, ly, lz, la, d, t;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        lz = longint'($signed(z));
        la = longint'($signed(a));
        d  = (lz >= 0) ? 1 : -1;
        t  = lx + d * floor_div(ly, k);
        ex = t[31:0];
        t  = ly + d * floor_div(lx, k);
        ey = t[31:0];
        t  = lz - d * la;
        ez = t[31:0];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input real exp, input real tol);
        real diff;
        diff = real'($signed(obs)) - exp;
        if (diff < 0.0) diff = -diff;
        checks++;
        assert (diff <= tol) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%0.1f (+/-%0.0f)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] ex, ey, ez, mx, my, mz;
    real         kh, ang;

    initial begin
        RST_N = 1'b0;
        a_ix = 32'h1234_5678; a_iy = 32'h0F0F_0F0F; a_iz = 32'h0000_4000; a_lut = 32'h8C9F;
        b_ix = 32'hDEAD_BEEF; b_iy = 32'h0000_1111; b_iz = 32'h8000_0000; b_lut = 32'h4163;
        chx = 32'h0001_3521; chy = 32'h0; chz = 32'h0000_8000;
        repeat (3) tick();
        check("reset_ox", a_ox, 32'h0);
        check("reset_oy", a_oy, 32'h0);
        check("reset_oz", a_oz, 32'h0);
        check("reset_b_oz", b_oz, 32'h0);
        RST_N = 1'b1;

        a_ix = 32'h0001_0000; a_iy = 32'h0; a_iz = 32'h0000_8000; a_lut = 32'h8C9F;
        tick();
        check("pos_ox", a_ox, 32'h0001_0000);
        check("pos_oy", a_oy, 32'h0000_8000);
        check("pos_oz", a_oz, 32'hFFFF_F361);

        a_iz = 32'hFFFF_8000;
        tick();
        check("neg_ox", a_ox, 32'h0001_0000);
        check("neg_oy", a_oy, 32'hFFFF_8000);
        check("neg_oz", a_oz, 32'h0000_0C9F);

        b_ix = 32'h0; b_iy = 32'hFFFF_FFFC; b_iz = 32'h0; b_lut = 32'h4163;
        tick();
        check("zero_ox", b_ox, 32'hFFFF_FFFF);
        check("zero_oy", b_oy, 32'hFFFF_FFFC);
        check("zero_oz", b_oz, 32'hFFFF_BE9D);

        a_ix = 32'h7FFF_FFFF; a_iy = 32'h7FFF_FFFF; a_iz = 32'h0; a_lut = 32'h8C9F;
        tick();
        check("wrap_ox", a_ox, 32'hBFFF_FFFE);
        check("wrap_oy", a_oy, 32'hBFFF_FFFE);
        check("wrap_oz", a_oz, 32'hFFFF_7361);

        #2 RST_N = 1'b0;
        #1;
        check("async_ox", a_ox, 32'h0);
        check("async_oy", a_oy, 32'h0);
        check("async_oz", a_oz, 32'h0);
        tick();
        RST_N = 1'b1;

        for (int i = 0; i < 5; i++) begin
            a_ix = $urandom; a_iy = $urandom; a_iz = $urandom; a_lut = $urandom;
            b_ix = $urandom; b_iy = $urandom; b_iz = $urandom; b_lut = $urandom_range(32'hFFFF);
            model(1, a_ix, a_iy, a_iz, a_lut, ex, ey, ez);
            model(2, b_ix, b_iy, b_iz, b_lut, mx, my, mz);
            tick();
            check($sformatf("rand%0d_a_ox", i), a_ox, ex);
            check($sformatf("rand%0d_a_oy", i), a_oy, ey);
            check($sformatf("rand%0d_a_oz", i), a_oz, ez);
            check($sformatf("rand%0d_b_ox", i), b_ox, mx);
            check($sformatf("rand%0d_b_oy", i), b_oy, my);
            check($sformatf("rand%0d_b_oz", i), b_oz, mz);
        end

        chx = 32'h0001_3521; chy = 32'h0; chz = 32'h0000_8000;
        repeat (16) tick();
        mx = chx; my = chy; mz = chz;
        for (int k = 1; k <= 16; k++) begin
            model(k, mx, my, mz, tbl[k], ex, ey, ez);
            mx = ex; my = ey; mz = ez;
        end
        check("chain_x", sx[16], mx);
        check("chain_y", sy[16], my);
        check("chain_z", sz[16], mz);

        // Without repeated iterations the chain gain is prod sqrt(1-4^-i), not the 1/K' seed
        kh = 1.0;
        for (int k = 1; k <= 16; k++) kh = kh * $sqrt(1.0 - (4.0 ** (-k)));
        ang = 0.5 - real'($signed(mz)) / 65536.0;
        check_near("chain_cosh", sx[16], real'($signed(chx)) * kh * $cosh(ang), 32.0);
        check_near("chain_sinh", sy[16], real'($signed(chx)) * kh * $sinh(ang), 32.0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
